gpo_shift_out: RTL and testbench

//  Downstream of the GPO register. Serializes the parallel 8-bit gpo value into an

---
 rtl/gpo_shift_out.sv | 202 ++++++++++++++++++++
 tb/tb_gpo_shift_out.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpo_shift_out.sv
// gpo_shift_out
// Serializes the parallel GPO value into an external 74HC595-style shift/latch
// register over three pins (sr_ser, sr_clk, sr_latch). A transfer starts once
// after every reset, whenever gpo_in differs from the last shipped value, and
// on an explicit force_req pulse.
//
// Build option: define GPO_SR_OE_EN to add sr_oe_n, the active-low output
// enable of the external part. It stays high from reset until the first
// completed transfer.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a transfer request, busy=0
// LOAD     | value captured, first bit presented on sr_ser
// SHIFT_LO | sr_clk low for CLK_DIV cycles
// SHIFT_HI | sr_clk high for CLK_DIV cycles, external part sampled
// LATCH    | sr_latch high for CLK_DIV cycles
// DONE     | one-cycle done pulse, then back to IDLE
module gpo_shift_out #(
  parameter int WIDTH     = 8,
  parameter int CLK_DIV   = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gpo_in,
  input  logic             force_req,
  output logic             sr_ser,
  output logic             sr_clk,
  output logic             sr_latch,
  output logic             busy,
  output logic             done
`ifdef GPO_SR_OE_EN
  ,
  output logic             sr_oe_n
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_SHIFT_LO = 3'd2;
  localparam logic [2:0] S_SHIFT_HI = 3'd3;
  localparam logic [2:0] S_LATCH    = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shadow_q;
  logic             init_pend_q;
  logic             force_pend_q;
  logic             req;
  logic             capture;
  logic             shift_en;
  logic             div_last;
  logic             out_bit;

  assign req      = init_pend_q | force_pend_q | force_req | (gpo_in != shadow_q);
  assign div_last = (div_q == DIV_LAST);
  assign out_bit  = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];

  // Next-state, counter reload and shift/capture strobes.
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    capture  = 1'b0;
    shift_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_LOAD;
          div_d   = '0;
          bit_d   = '0;
          capture = 1'b1;
        end
      end
      S_LOAD: begin
        state_d = S_SHIFT_LO;
        div_d   = '0;
        bit_d   = '0;
      end
      S_SHIFT_LO: begin
        if (div_last) begin
          state_d = S_SHIFT_HI;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_LATCH;
            bit_d   = '0;
          end else begin
            state_d  = S_SHIFT_LO;
            bit_d    = bit_q + 1'b1;
            shift_en = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (div_last) begin
          state_d = S_DONE;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        div_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // State and timing counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
    end
  end

  // Shift register and shadow copy of the value being shipped. The shift
  // happens on the SHIFT_HI->SHIFT_LO edge so sr_ser moves while sr_clk falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q  <= '0;
      shadow_q <= '0;
    end else if (capture) begin
      shreg_q  <= gpo_in;
      shadow_q <= gpo_in;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) shreg_q <= shreg_q << 1;
      else                shreg_q <= shreg_q >> 1;
    end
  end

  // Pending requests: one init transfer after reset, and forces that arrive
  // while busy collapse into a single resend.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      init_pend_q  <= 1'b1;
      force_pend_q <= 1'b0;
    end else if (capture) begin
      init_pend_q  <= 1'b0;
      force_pend_q <= 1'b0;
    end else if (force_req && (state_q != S_IDLE)) begin
      force_pend_q <= 1'b1;
    end
  end

  // Pin outputs decode straight from state so reset drops them immediately.
  always_comb begin
    sr_ser   = 1'b0;
    sr_clk   = 1'b0;
    sr_latch = 1'b0;
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    case (state_q)
      S_LOAD, S_SHIFT_LO: sr_ser = out_bit;
      S_SHIFT_HI: begin
        sr_ser = out_bit;
        sr_clk = 1'b1;
      end
      S_LATCH: sr_latch = 1'b1;
      default: ;
    endcase
  end

`ifdef GPO_SR_OE_EN
  // Keep the external outputs disabled until the first value is latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  sr_oe_n <= 1'b1;
    else if (state_q == S_DONE) sr_oe_n <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_gpo_shift_out.sv
// Bench for gpo_shift_out: an MSB-first and an LSB-first instance share the
// same stimulus. A transfer-level model predicts which values get shipped and
// when busy/done are high; monitors rebuild each latched word with a 595 model.
module tb_gpo_shift_out;

  localparam int W    = 8;
  localparam int DIV  = 2;
  localparam int XFER = 1 + 2 * W * DIV + DIV + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] gpo;
  logic         force_req;
  logic ser0, sck0, lat0, busy0, done0;
  logic ser1, sck1, lat1, busy1, done1;
`ifdef GPO_SR_OE_EN
  logic oe0, oe1;
`endif

  always #5 clk = ~clk;

  gpo_shift_out #(.WIDTH(W), .CLK_DIV(DIV), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .gpo_in(gpo), .force_req(force_req),
    .sr_ser(ser0), .sr_clk(sck0), .sr_latch(lat0), .busy(busy0), .done(done0)
`ifdef GPO_SR_OE_EN
    , .sr_oe_n(oe0)
`endif
  );

  gpo_shift_out #(.WIDTH(W), .CLK_DIV(DIV), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .gpo_in(gpo), .force_req(force_req),
    .sr_ser(ser1), .sr_clk(sck1), .sr_latch(lat1), .busy(busy1), .done(done1)
`ifdef GPO_SR_OE_EN
    , .sr_oe_n(oe1)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = v[7-k];
    return r;
  endfunction

  // Transfer-level reference model.
  int           m_rem    = 0;
  logic         m_init   = 1'b1;
  logic         m_fpend  = 1'b0;
  logic [W-1:0] m_shadow = '0;
  logic         m_oe     = 1'b1;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_rem = 0; m_init = 1'b1; m_fpend = 1'b0; m_shadow = '0; m_oe = 1'b1;
    end else if (m_rem == 0) begin
      if (m_init || m_fpend || force_req || (gpo != m_shadow)) begin
        q0.push_back(gpo);
        q1.push_back(gpo);
        m_shadow = gpo;
        m_init   = 1'b0;
        m_fpend  = 1'b0;
        m_rem    = XFER;
      end
    end else begin
      if (force_req) m_fpend = 1'b1;
      if (m_rem == 1) m_oe = 1'b0;
      m_rem--;
    end
  end

  // Monitor state, index 0 = MSB-first instance, 1 = LSB-first instance.
  int         rise[2];
  int         lathi[2];
  logic       pclk[2], plat[2], pser[2];
  logic [7:0] sh595[2];

  task automatic mon(input int i, input logic ser, input logic sck, input logic lat);
    logic [7:0] v;
    logic       have;
    if (sck && !pclk[i]) begin
      check("ser_setup", ser, pser[i]);
      sh595[i] = {sh595[i][6:0], ser};
      rise[i]++;
    end
    if (lat && !plat[i]) begin
      have = (i == 0) ? (q0.size() != 0) : (q1.size() != 0);
      check("xfer_expected", have, 1'b1);
      if (have) begin
        if (i == 0) v = q0.pop_front();
        else        v = rev8(q1.pop_front());
        check((i == 0) ? "latched_msb" : "latched_lsb", sh595[i], v);
        check("srclk_rises", rise[i], W);
      end
      rise[i]  = 0;
      lathi[i] = 0;
    end
    if (lat) lathi[i]++;
    if (!lat && plat[i]) check("latch_width", lathi[i], DIV);
    pclk[i] = sck;
    plat[i] = lat;
    pser[i] = ser;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rise[i] = 0; lathi[i] = 0; pclk[i] = 0; plat[i] = 0; pser[i] = 0; sh595[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst) begin
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
          rise[i] = 0; lathi[i] = 0; pclk[i] = 0; plat[i] = 0; pser[i] = 0;
        end
        check("rst_outs", {busy0, done0, ser0, sck0, lat0, busy1, sck1, lat1}, 8'h00);
      end else begin
        mon(0, ser0, sck0, lat0);
        mon(1, ser1, sck1, lat1);
        check("busy", busy0, m_rem > 0);
        check("done", done0, m_rem == 1);
        check("busy_lsb", busy1, m_rem > 0);
        check("done_lsb", done1, m_rem == 1);
      end
`ifdef GPO_SR_OE_EN
      check("oe_n", oe0, m_oe);
      check("oe_n_lsb", oe1, m_oe);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (!(m_rem == 0 && !m_init && !m_fpend && gpo == m_shadow) && n < lim) begin
      step();
      n++;
    end
    check("idle_reached", n < lim, 1'b1);
    step();
    step();
    check("queue_drained", q0.size() + q1.size(), 0);
  endtask

  task automatic wait_rise(input int r);
    int n;
    n = 0;
    while (rise[0] < r && n < 500) begin
      step();
      n++;
    end
    check("rise_reached", rise[0] >= r, 1'b1);
  endtask

  task automatic pulse_force();
    force_req = 1'b1;
    step();
    force_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    gpo = '0;
    force_req = 1'b0;
    repeat (3) step();
    check("rst_busy", busy0, 1'b0);
    check("rst_latch", lat0, 1'b0);
    rst = 1'b1;

    // init transfer of 0x00, then nothing more
    wait_idle(300);
    repeat (20) step();

    // 0xA5 on both bit orders
    gpo = 8'hA5;
    wait_idle(300);

    // change during a transfer: 0xA5 completes, then 0x3C
    gpo = 8'h00;
    wait_idle(300);
    gpo = 8'hA5;
    wait_rise(4);
    gpo = 8'h3C;
    wait_idle(300);

    // single force in IDLE, then three forces while busy
    pulse_force();
    wait_idle(300);
    pulse_force();
    wait_rise(2);
    pulse_force();
    wait_rise(5);
    pulse_force();
    wait_rise(7);
    pulse_force();
    wait_idle(300);

    // force coincident with a value change
    gpo = 8'h5A;
    pulse_force();
    wait_idle(300);

    // reset during SHIFT_HI of bit 5
    gpo = 8'hFF;
    wait_rise(6);
    check("pre_abort_clk", sck0, 1'b1);
    check("pre_abort_ser", ser0, 1'b1);
    rst = 1'b0;
    #1;
    check("abort_outs", {sck0, ser0, lat0, busy0, done0}, 5'b0);
    gpo = 8'h81;
    step();
    step();
    rst = 1'b1;
    wait_idle(300);

    // randomized changes and forces
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) begin
        gpo = W'($urandom);
        step();
      end else if (r < 7) begin
        pulse_force();
      end else if (r < 8) begin
        gpo = W'($urandom);
        pulse_force();
      end else begin
        gpo = gpo ^ W'(1 << $urandom_range(0, W - 1));
        step();
      end
      repeat ($urandom_range(0, 50)) step();
    end
    wait_idle(600);

`ifdef GPO_SR_OE_EN
    rst = 1'b0;
    #1;
    check("oe_after_rst", oe0, 1'b1);
    step();
    rst = 1'b1;
    wait_idle(300);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
